// File: rtl/detector_ctrl_pkg.sv
// Shared types and default sizing for the detector sequencer.
// Optional feature macro used by detector_ctrl: DETECTOR_CTRL_SPKCNT_EN.
package detector_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    REFR
  } state_t;

  localparam int THR_W_DEF     = 8;
  localparam int REFR_W_DEF    = 8;
  localparam int TS_W_DEF      = 16;
  localparam int SETTLE_CYCLES = 16;

  localparam logic [15:0] SPKCNT_MAX = 16'hFFFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/detector_ctrl_evreg.sv
// One-entry valid/ready holding register for qualified spike events.
// A push into a full register that is not being popped is dropped and raises a sticky overflow flag.
module detector_ctrl_evreg
  import detector_ctrl_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [TS_W-1:0] push_ts,
  input  logic            ready,
  input  logic            clr_ovf,
  output logic            valid,
  output logic [TS_W-1:0] ts,
  output logic            ovf
);

  logic free;

  assign free = !valid || ready;

  // Hold the event until handshake; a pop and push in the same cycle loads the new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      ts    <= '0;
    end else if (push && free) begin
      valid <= 1'b1;
      ts    <= push_ts;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Sticky overflow: set when an event is lost, cleared only when a new run is started.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else if (push && !free) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/detector_ctrl.sv
// Sequencer for the iir -> enfasi -> detector spike chain: serial threshold load, settle wait,
// refractory-masked spike qualification with timestamps into a one-entry event register.
// Optional macro DETECTOR_CTRL_SPKCNT_EN adds the saturating accepted-spike counter spk_cnt.
module detector_ctrl
  import detector_ctrl_pkg::*;
#(
  parameter int THR_W      = THR_W_DEF,
  parameter int REFR_W     = REFR_W_DEF,
  parameter int TS_W       = TS_W_DEF,
  parameter int SETTLE_LEN = SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [THR_W-1:0]  cfg_thr,
  input  logic [REFR_W-1:0] cfg_refr,
  input  logic              start,
  input  logic              stop,
  input  logic              spike_in,
  output logic              det_enable,
  output logic              det_din,
  output logic              busy,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [TS_W-1:0]   ev_ts,
  output logic              ev_ovf
`ifdef DETECTOR_CTRL_SPKCNT_EN
  ,
  output logic [15:0]       spk_cnt
`endif
);

  localparam int SEQ_W = $clog2(max_int(THR_W, SETTLE_LEN) + 1);

  state_t state, next_state;

  logic [THR_W-1:0]  cfg_thr_q;
  logic [REFR_W-1:0] cfg_refr_q;
  logic [THR_W-1:0]  shift_q;
  logic [THR_W-1:0]  thr_src;
  logic [THR_W-1:0]  load_word;
  logic [REFR_W-1:0] refr_cnt;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [TS_W-1:0]   ts;
  logic              start_ok;
  logic              stop_ok;
  logic              accept;
  logic              running;

  assign start_ok = (state == IDLE) && start;
  assign stop_ok  = (state != IDLE) && stop;
  assign running  = (state == RUN) || (state == REFR);
  assign accept   = (state == RUN) && spike_in && !stop;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; stop overrides every phase except IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (seq_cnt == SEQ_W'(THR_W - 1)) next_state = SETTLE;
      SETTLE:  if (seq_cnt == SEQ_W'(SETTLE_LEN - 1)) next_state = RUN;
      RUN:     if (spike_in && (cfg_refr_q != '0)) next_state = REFR;
      REFR:    if (refr_cnt <= REFR_W'(1)) next_state = RUN;
      default: next_state = IDLE;
    endcase
    if (stop_ok) next_state = IDLE;
  end

  // Configuration is only writable while idle so a running session sees a fixed setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_thr_q  <= '0;
      cfg_refr_q <= '0;
    end else if ((state == IDLE) && cfg_we) begin
      cfg_thr_q  <= cfg_thr;
      cfg_refr_q <= cfg_refr;
    end
  end

  // Phase counter for LOAD and SETTLE; restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_cnt <= '0;
    end else if ((next_state == state) && ((state == LOAD) || (state == SETTLE))) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end else begin
      seq_cnt <= '0;
    end
  end

  // The first bit comes from the freshly written word when start and cfg_we coincide.
  always_comb begin
    thr_src   = cfg_we ? cfg_thr : cfg_thr_q;
    load_word = (state == IDLE) ? thr_src : (shift_q << 1);
  end

  // Registered serial load: MSB first, both lines forced low outside LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      det_enable <= 1'b0;
      det_din    <= 1'b0;
    end else if (next_state == LOAD) begin
      shift_q    <= load_word;
      det_enable <= 1'b1;
      det_din    <= load_word[THR_W-1];
    end else begin
      det_enable <= 1'b0;
      det_din    <= 1'b0;
    end
  end

  // Refractory countdown: loaded on an accepted spike, REFR lasts exactly cfg_refr cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refr_cnt <= '0;
    end else if ((state == RUN) && (next_state == REFR)) begin
      refr_cnt <= cfg_refr_q;
    end else if (next_state == REFR) begin
      refr_cnt <= refr_cnt - REFR_W'(1);
    end else begin
      refr_cnt <= '0;
    end
  end

  // Free-running timestamp while running, zero otherwise so the first RUN cycle reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts <= '0;
    end else if (running && (next_state != IDLE)) begin
      ts <= ts + TS_W'(1);
    end else begin
      ts <= '0;
    end
  end

  detector_ctrl_evreg #(
    .TS_W(TS_W)
  ) u_evreg (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_ts (ts),
    .ready   (ev_ready),
    .clr_ovf (start_ok),
    .valid   (ev_valid),
    .ts      (ev_ts),
    .ovf     (ev_ovf)
  );

`ifdef DETECTOR_CTRL_SPKCNT_EN
  // Saturating count of accepted spikes, including those lost to overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spk_cnt <= '0;
    end else if (start_ok) begin
      spk_cnt <= '0;
    end else if (accept && (spk_cnt != SPKCNT_MAX)) begin
      spk_cnt <= spk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_detector_ctrl.sv
// Self-checking bench for detector_ctrl: a vector table for the threshold load, hand-written
// corner sequences, and randomized traffic against a session/arithmetic reference model.
// Honours DETECTOR_CTRL_SPKCNT_EN when the design is built with it.
module tb_detector_ctrl;

  localparam int LOAD_CYC   = 8;
  localparam int SETTLE_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_thr;
  logic [7:0]  cfg_refr;
  logic        start;
  logic        stop;
  logic        spike_in;
  logic        det_enable;
  logic        det_din;
  logic        busy;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_ts;
  logic        ev_ovf;
`ifdef DETECTOR_CTRL_SPKCNT_EN
  logic [15:0] spk_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: a session is described by its age since start; phases and the
  // timestamp follow from that age by arithmetic.
  bit          m_active;
  int          m_age;
  logic [7:0]  m_thr;
  logic [7:0]  m_refr;
  int          m_next_ok;
  bit          m_valid;
  logic [15:0] m_ts;
  bit          m_ovf;
  int          m_cnt;

  typedef struct {
    logic       we;
    logic [7:0] thr;
    logic [7:0] refr;
    logic       st;
    logic       sp;
    logic       spk;
    logic       rdy;
    logic       exp_en;
    logic       exp_din;
    logic       exp_busy;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[25];

  logic       r_we, r_st, r_sp, r_spk, r_rdy;
  logic [7:0] r_thr, r_refr;
  logic [7:0] word;

  always #5 clk = ~clk;

  detector_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_thr    (cfg_thr),
    .cfg_refr   (cfg_refr),
    .start      (start),
    .stop       (stop),
    .spike_in   (spike_in),
    .det_enable (det_enable),
    .det_din    (det_din),
    .busy       (busy),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ts      (ev_ts),
    .ev_ovf     (ev_ovf)
`ifdef DETECTOR_CTRL_SPKCNT_EN
    ,
    .spk_cnt    (spk_cnt)
`endif
  );

  function automatic void model_reset();
    m_active  = 1'b0;
    m_age     = 0;
    m_thr     = 8'h00;
    m_refr    = 8'h00;
    m_next_ok = 0;
    m_valid   = 1'b0;
    m_ts      = 16'h0000;
    m_ovf     = 1'b0;
    m_cnt     = 0;
  endfunction

  function automatic void model_step(input logic we, input logic [7:0] thr, input logic [7:0] refr,
                                     input logic st, input logic sp, input logic spk, input logic rdy);
    bit accept;
    bit free;
    int idx;
    accept = 1'b0;
    idx    = 0;
    if (!m_active) begin
      if (we) begin
        m_thr  = thr;
        m_refr = refr;
      end
    end else begin
      idx    = m_age - (LOAD_CYC + SETTLE_CYC);
      accept = !sp && spk && (idx >= 0) && (idx >= m_next_ok);
      if (accept) begin
        m_next_ok = idx + int'(m_refr) + 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    free = !m_valid || rdy;
    if (accept && free) begin
      m_valid = 1'b1;
      m_ts    = 16'(idx);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (accept && !free) m_ovf = 1'b1;
    if (!m_active && st) begin
      m_active  = 1'b1;
      m_age     = 0;
      m_next_ok = 0;
      m_ovf     = 1'b0;
      m_cnt     = 0;
    end else if (m_active) begin
      if (sp) m_active = 1'b0;
      else m_age++;
    end
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic e_en;
    logic e_din;
    e_en  = m_active && (m_age < LOAD_CYC);
    e_din = 1'b0;
    if (e_en) e_din = m_thr[7 - m_age];
    checkVal("det_enable", 32'(det_enable), 32'(e_en));
    checkVal("det_din",    32'(det_din),    32'(e_din));
    checkVal("busy",       32'(busy),       32'(m_active));
    checkVal("ev_valid",   32'(ev_valid),   32'(m_valid));
    checkVal("ev_ts",      32'(ev_ts),      32'(m_ts));
    checkVal("ev_ovf",     32'(ev_ovf),     32'(m_ovf));
`ifdef DETECTOR_CTRL_SPKCNT_EN
    checkVal("spk_cnt",    32'(spk_cnt),    32'(m_cnt));
`endif
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] thr, input logic [7:0] refr,
                               input logic st, input logic sp, input logic spk, input logic rdy);
    cfg_we   = we;
    cfg_thr  = thr;
    cfg_refr = refr;
    start    = st;
    stop     = sp;
    spike_in = spk;
    ev_ready = rdy;
    model_step(we, thr, refr, st, sp, spk, rdy);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic spk, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, spk, rdy);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_det_enable"}, 32'(det_enable), 32'd0);
    checkVal({tag, "_det_din"},    32'(det_din),    32'd0);
    checkVal({tag, "_busy"},       32'(busy),       32'd0);
    checkVal({tag, "_ev_valid"},   32'(ev_valid),   32'd0);
    checkVal({tag, "_ev_ts"},      32'(ev_ts),      32'd0);
    checkVal({tag, "_ev_ovf"},     32'(ev_ovf),     32'd0);
`ifdef DETECTOR_CTRL_SPKCNT_EN
    checkVal({tag, "_spk_cnt"},    32'(spk_cnt),    32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Threshold 8'hA5 loaded with start and cfg_we together; spikes held high through LOAD/SETTLE.
    vecs[0] = '{1'b1, 8'hA5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 8; k < 25; k++)
      vecs[k] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst      = 1'b0;
    cfg_we   = 1'b0;
    cfg_thr  = 8'h00;
    cfg_refr = 8'h00;
    start    = 1'b0;
    stop     = 1'b0;
    spike_in = 1'b0;
    ev_ready = 1'b0;
    model_reset();
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Serial load and settle window.
    for (int k = 0; k < 25; k++) begin
      applyStimulus(vecs[k].we, vecs[k].thr, vecs[k].refr, vecs[k].st, vecs[k].sp, vecs[k].spk, vecs[k].rdy);
      checkVal($sformatf("tbl%0d_en", k),    32'(det_enable), 32'(vecs[k].exp_en));
      checkVal($sformatf("tbl%0d_din", k),   32'(det_din),    32'(vecs[k].exp_din));
      checkVal($sformatf("tbl%0d_busy", k),  32'(busy),       32'(vecs[k].exp_busy));
      checkVal($sformatf("tbl%0d_valid", k), 32'(ev_valid),   32'(vecs[k].exp_valid));
    end

    // Refractory of 3: spikes held for six cycles from ts=0 give events at ts 0 and 4 only.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("refr_ev0_valid", 32'(ev_valid), 32'd1);
    checkVal("refr_ev0_ts",    32'(ev_ts),    32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("refr_pop0", 32'(ev_valid), 32'd0);
    idle(2, 1'b1, 1'b0);
    checkVal("refr_masked", 32'(ev_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("refr_ev1_valid", 32'(ev_valid), 32'd1);
    checkVal("refr_ev1_ts",    32'(ev_ts),    32'd4);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("refr_pop1", 32'(ev_valid), 32'd0);
    idle(4, 1'b0, 1'b1);
    checkVal("refr_no_ovf", 32'(ev_ovf), 32'd0);

    // Overflow: no consumer, refractory 0, spikes at ts 5 and 9.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    checkVal("stop_run_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(LOAD_CYC + SETTLE_CYC + 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("ovf_first_ts",  32'(ev_ts),  32'd5);
    checkVal("ovf_first_ovf", 32'(ev_ovf), 32'd0);
    idle(3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("ovf_kept_ts", 32'(ev_ts),    32'd5);
    checkVal("ovf_valid",   32'(ev_valid), 32'd1);
    checkVal("ovf_set",     32'(ev_ovf),   32'd1);
    idle(1, 1'b0, 1'b1);
    checkVal("ovf_pop_valid",  32'(ev_valid), 32'd0);
    checkVal("ovf_sticky",     32'(ev_ovf),   32'd1);

    // Abort mid-load, then restart with a fresh word.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkVal("start_clr_ovf", 32'(ev_ovf),     32'd0);
    checkVal("start_enable",  32'(det_enable), 32'd1);
    idle(3, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("abort_enable", 32'(det_enable), 32'd0);
    checkVal("abort_busy",   32'(busy),       32'd0);
    word = 8'h3C;
    applyStimulus(1'b1, word, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LOAD_CYC; i++) begin
      checkVal($sformatf("reload_en%0d", i),  32'(det_enable), 32'd1);
      checkVal($sformatf("reload_din%0d", i), 32'(det_din),    32'(word[7 - i]));
      idle(1, 1'b0, 1'b0);
    end
    checkVal("reload_done_en", 32'(det_enable), 32'd0);

    // Timestamp wrap: spike at 16'hFFFF, then after the wrap with a same-cycle pop and push.
    idle(SETTLE_CYC + 65535, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("wrap_ts_max", 32'(ev_ts), 32'h0000FFFF);
    idle(1, 1'b0, 1'b0);
    checkVal("wrap_hold_ts", 32'(ev_ts), 32'h0000FFFF);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("wrap_valid", 32'(ev_valid), 32'd1);
    checkVal("wrap_ts",    32'(ev_ts),    32'd1);

    // Asynchronous reset mid-run with an event pending.
    rst = 1'b0;
    #2;
    checkAllZero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(20, 1'b1, 1'b0);
    checkVal("post_rst_busy",  32'(busy),     32'd0);
    checkVal("post_rst_valid", 32'(ev_valid), 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      r_we   = ($urandom_range(0, 7) == 0);
      r_thr  = 8'($urandom);
      r_refr = 8'($urandom_range(0, 5));
      r_st   = ($urandom_range(0, 3) == 0);
      r_sp   = ($urandom_range(0, 63) == 0);
      r_spk  = ($urandom_range(0, 2) == 0);
      r_rdy  = ($urandom_range(0, 1) == 0);
      applyStimulus(r_we, r_thr, r_refr, r_st, r_sp, r_spk, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
